// File: rtl/keypad_scanner.sv
// Debounced 4x4 matrix-keypad scanner: walks an active-low row drive, debounces the
// synchronized columns on divider ticks and reports one {row,col} code per keystroke.
module keypad_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DB_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] column_in,
    output logic [3:0] row_sweep,
    output logic [7:0] enc_out,
    output logic       pressed
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DB_COUNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DB_COUNT);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    logic [3:0]       r_sync1;
    logic [3:0]       r_col_s;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_state;
    logic [3:0]       r_row;
    logic [3:0]       r_cap_col;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_enc;
    logic             r_pressed;

    logic             w_tick;
    logic [3:0]       w_col_n;
    logic             w_idle;
    logic             w_single;
    logic [3:0]       w_row_next;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_tick     = (r_div == DIV_LAST);
    assign w_col_n    = ~r_col_s;
    assign w_idle     = (r_col_s == 4'b1111);
    // Exactly one closed column: non-zero and a power of two.
    assign w_single   = (w_col_n != 4'd0) && ((w_col_n & (w_col_n - 4'd1)) == 4'd0);
    assign w_row_next = {r_row[2:0], r_row[3]};
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 4'b1111;
            r_col_s   <= 4'b1111;
            r_div     <= '0;
            r_state   <= ST_SCAN;
            r_row     <= 4'b1110;
            r_cap_col <= 4'b0000;
            r_cnt     <= '0;
            r_enc     <= 8'h00;
            r_pressed <= 1'b0;
        end else begin
            r_sync1   <= column_in;
            r_col_s   <= r_sync1;
            r_pressed <= 1'b0;
            r_div     <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) begin
                case (r_state)
                    ST_SCAN: begin
                        if (w_single) begin
                            r_cap_col <= w_col_n;
                            r_cnt     <= CNT_W'(1);
                            r_state   <= ST_DEBOUNCE;
                        end else begin
                            r_row <= w_row_next;
                        end
                    end
                    ST_DEBOUNCE: begin
                        // Multi or idle samples can never equal the captured one-hot column.
                        if (w_col_n == r_cap_col) begin
                            if (w_cnt_inc == CNT_DONE) begin
                                r_enc     <= {~r_row, r_cap_col};
                                r_pressed <= 1'b1;
                                r_cnt     <= '0;
                                r_state   <= ST_HELD;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt   <= '0;
                            r_row   <= w_row_next;
                            r_state <= ST_SCAN;
                        end
                    end
                    ST_HELD: begin
                        if (w_idle) begin
                            if (w_cnt_inc == CNT_DONE) begin
                                r_cnt   <= '0;
                                r_row   <= w_row_next;
                                r_state <= ST_SCAN;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= ST_SCAN;
                    end
                endcase
            end
        end
    end

    assign row_sweep = r_row;
    assign enc_out   = r_enc;
    assign pressed   = r_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model closes switches against the row drive and
// a scoreboard matches each pressed strobe to the key code queued when it was closed.
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] column_in;
    logic [3:0] row_sweep;
    logic [7:0] enc_out;
    logic       pressed;

    logic [3:0] keys [4];
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic [7:0] last_enc;
    int         n_cmp;
    int         n_err;
    int         n_pulses;

    keypad_scanner #(.SCAN_DIV(4), .DB_COUNT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .column_in (column_in),
        .row_sweep (row_sweep),
        .enc_out   (enc_out),
        .pressed   (pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column c is pulled low while any closed key (r,c) sits on the driven row.
    always_comb begin
        column_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r][c] && !row_sweep[r]) column_in[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && pressed) begin
            n_pulses++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: enc_out=%b, no key expected", enc_out);
            end else begin
                mon_exp = exp_q.pop_front();
                last_enc = mon_exp;
                if (enc_out !== mon_exp) begin
                    n_err++;
                    $display("FAIL pulse_code: enc_out=%b, required %b", enc_out, mon_exp);
                end
            end
        end
    end

    task automatic wait_row(input logic [3:0] want, input int budget, input string name,
                            output int waited);
        int k;
        k = 0;
        while (row_sweep === want && k < budget) begin
            @(negedge clk);
            k++;
        end
        waited = 0;
        while (row_sweep !== want && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (row_sweep !== want) begin
            n_err++;
            $display("FAIL %s: row_sweep=%b, required %b within %0d cycles", name, row_sweep, want, budget);
        end
    endtask

    task automatic wait_pulse(input int budget, input string name, output int waited);
        waited = 0;
        while (pressed !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (pressed !== 1'b1) begin
            n_err++;
            $display("FAIL %s: pressed=%b, required 1 within %0d cycles", name, pressed, budget);
        end
    endtask

    task automatic test_reset();
        int w;
        int dwell;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (row_sweep !== 4'b1110) begin n_err++; $display("FAIL reset_row: got %b, required 1110", row_sweep); end
        n_cmp++;
        if (enc_out !== 8'h00) begin n_err++; $display("FAIL reset_enc: got %h, required 00", enc_out); end
        n_cmp++;
        if (pressed !== 1'b0) begin n_err++; $display("FAIL reset_pressed: got %b, required 0", pressed); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_row(4'b1101, 40, "reset_first_rotate", w);
        dwell = 0;
        while (row_sweep === 4'b1101 && dwell < 20) begin
            @(negedge clk);
            dwell++;
        end
        n_cmp++;
        if (dwell !== 4 || row_sweep !== 4'b1011) begin
            n_err++;
            $display("FAIL scan_dwell: dwell=%0d next_row=%b, required 4 and 1011", dwell, row_sweep);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (row_sweep !== 4'b1110) begin n_err++; $display("FAIL midcycle_reset_row: got %b, required 1110", row_sweep); end
        n_cmp++;
        if (enc_out !== 8'h00 || pressed !== 1'b0) begin
            n_err++;
            $display("FAIL midcycle_reset_out: enc=%h pressed=%b, required 00 0", enc_out, pressed);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_press();
        int w;
        int p0;
        logic frozen;
        wait_row(4'b1110, 40, "single_find_row0", w);
        keys[2][1] = 1'b1;
        exp_q.push_back(8'b0100_0010);
        p0 = n_pulses;
        wait_row(4'b1011, 40, "single_reach_row2", w);
        wait_pulse(30, "single_pulse", w);
        n_cmp++;
        if (w !== 12) begin n_err++; $display("FAIL single_latency: %0d cycles after row2 drive, required 12", w); end
        frozen = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (row_sweep !== 4'b1011) frozen = 1'b0;
        end
        n_cmp++;
        if (!frozen) begin n_err++; $display("FAIL single_row_frozen: row=%b, required held at 1011", row_sweep); end
        n_cmp++;
        if (n_pulses - p0 !== 1) begin n_err++; $display("FAIL single_pulse_count: got %0d, required 1", n_pulses - p0); end
        n_cmp++;
        if (enc_out !== 8'b0100_0010) begin n_err++; $display("FAIL single_enc_hold: got %b, required 01000010", enc_out); end
        keys[2][1] = 1'b0;
        wait_row(4'b0111, 40, "single_release", w);
    endtask

    task automatic test_bounce();
        int w;
        int p0;
        wait_row(4'b1110, 40, "bounce_find_row0", w);
        keys[0][3] = 1'b1;
        p0 = n_pulses;
        repeat (8) @(negedge clk);
        keys[0][3] = 1'b0;
        wait_row(4'b1101, 20, "bounce_resume", w);
        n_cmp++;
        if (w !== 4) begin n_err++; $display("FAIL bounce_resume_time: %0d cycles after opening, required 4", w); end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (n_pulses !== p0) begin n_err++; $display("FAIL bounce_no_pulse: got %0d pulses, required 0", n_pulses - p0); end
        n_cmp++;
        if (enc_out !== last_enc) begin n_err++; $display("FAIL bounce_enc_hold: got %b, required %b", enc_out, last_enc); end
    endtask

    task automatic test_hold_release_repress();
        int w;
        int p0;
        wait_row(4'b1110, 40, "hold_find_row0", w);
        keys[3][0] = 1'b1;
        exp_q.push_back(8'b1000_0001);
        p0 = n_pulses;
        repeat (200) @(negedge clk);
        n_cmp++;
        if (n_pulses - p0 !== 1) begin n_err++; $display("FAIL hold_single_pulse: got %0d, required 1", n_pulses - p0); end
        n_cmp++;
        if (enc_out !== 8'b1000_0001 || row_sweep !== 4'b0111) begin
            n_err++;
            $display("FAIL hold_state: enc=%b row=%b, required 10000001 0111", enc_out, row_sweep);
        end
        keys[3][0] = 1'b0;
        wait_row(4'b1110, 40, "hold_release", w);
        keys[1][2] = 1'b1;
        exp_q.push_back(8'b0010_0100);
        wait_pulse(60, "repress_pulse", w);
        @(negedge clk);
        n_cmp++;
        if (n_pulses - p0 !== 2) begin n_err++; $display("FAIL repress_count: got %0d, required 2", n_pulses - p0); end
        n_cmp++;
        if (enc_out !== 8'b0010_0100) begin n_err++; $display("FAIL repress_enc: got %b, required 00100100", enc_out); end
        keys[1][2] = 1'b0;
        wait_row(4'b1011, 40, "repress_release", w);
    endtask

    task automatic test_multi();
        int w;
        int p0;
        wait_row(4'b1110, 40, "multi_find_row0", w);
        keys[1][0] = 1'b1;
        keys[1][3] = 1'b1;
        p0 = n_pulses;
        repeat (100) @(negedge clk);
        n_cmp++;
        if (n_pulses !== p0) begin n_err++; $display("FAIL multi_no_pulse: got %0d pulses, required 0", n_pulses - p0); end
        wait_row(4'b1101, 20, "multi_still_scanning", w);
        keys[1][3] = 1'b0;
        exp_q.push_back(8'b0010_0001);
        wait_pulse(60, "multi_single_pulse", w);
        @(negedge clk);
        n_cmp++;
        if (enc_out !== 8'b0010_0001) begin n_err++; $display("FAIL multi_enc: got %b, required 00100001", enc_out); end
        keys[1][0] = 1'b0;
        wait_row(4'b1011, 40, "multi_release", w);
    endtask

    task automatic test_reset_mid();
        int w;
        int p0;
        wait_row(4'b1110, 40, "rstmid_find_row0", w);
        keys[2][2] = 1'b1;
        p0 = n_pulses;
        wait_row(4'b1011, 40, "rstmid_reach_row2", w);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (row_sweep !== 4'b1110 || enc_out !== 8'h00 || pressed !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_values: row=%b enc=%h pressed=%b, required 1110 00 0", row_sweep, enc_out, pressed);
        end
        last_enc = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (n_pulses !== p0) begin n_err++; $display("FAIL rstmid_no_report: got %0d pulses, required 0", n_pulses - p0); end
        exp_q.push_back(8'b0100_0100);
        wait_row(4'b1011, 40, "rstmid_rescan_row2", w);
        wait_pulse(30, "rstmid_pulse", w);
        n_cmp++;
        if (w !== 12) begin n_err++; $display("FAIL rstmid_latency: %0d cycles after row2 drive, required 12", w); end
        keys[2][2] = 1'b0;
        wait_row(4'b0111, 40, "rstmid_release", w);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_pulses = 0;
        last_enc = 8'h00;
        for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
        test_reset();
        test_single_press();
        test_bounce();
        test_hold_release_repress();
        test_multi();
        test_reset_mid();
        repeat (10) @(negedge clk);
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d keys never reported, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
